// File: rtl/l2_cacheline_adaptor.sv
// rtl/l2_cacheline_adaptor.sv - splits 256-bit L2 line transfers into four 64-bit burst beats
module l2_cacheline_adaptor (
   input  logic         clk,
   input  logic         rst,
   input  logic         pmem_read,
   input  logic         pmem_write,
   input  logic [31:0]  pmem_address,
   input  logic [255:0] pmem_wdata,
   output logic [255:0] pmem_rdata,
   output logic         pmem_resp,
   output logic [31:0]  address_o,
   output logic         read_o,
   output logic         write_o,
   output logic [63:0]  burst_o,
   input  logic [63:0]  burst_i,
   input  logic         resp_i
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t         state;
   state_t         state_next;
   logic [1:0]     beat;
   logic [31:0]    addr;
   logic [255:0]   rbuf;
   logic [255:0]   wbuf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Write wins over a simultaneous read; the read is simply not latched.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (pmem_write)     state_next = WRITE;
            else if (pmem_read) state_next = READ;
         end
         READ, WRITE: begin
            if (resp_i && beat == 2'd3) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat <= 2'd0;
         addr <= 32'd0;
         rbuf <= 256'd0;
         wbuf <= 256'd0;
      end else begin
         case (state)
            IDLE: begin
               if (pmem_write) begin
                  addr <= {pmem_address[31:5], 5'b0};
                  wbuf <= pmem_wdata;
                  beat <= 2'd0;
               end else if (pmem_read) begin
                  addr <= {pmem_address[31:5], 5'b0};
                  beat <= 2'd0;
               end
            end
            READ: begin
               if (resp_i) begin
                  rbuf[{beat, 6'b0} +: 64] <= burst_i;
                  beat                     <= beat + 2'd1;
               end
            end
            WRITE: begin
               if (resp_i) beat <= beat + 2'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      read_o    = 1'b0;
      write_o   = 1'b0;
      pmem_resp = 1'b0;
      address_o = 32'd0;
      burst_o   = 64'd0;
      case (state)
         READ: begin
            read_o    = 1'b1;
            address_o = addr;
         end
         WRITE: begin
            write_o   = 1'b1;
            address_o = addr;
            burst_o   = wbuf[{beat, 6'b0} +: 64];
         end
         DONE:    pmem_resp = 1'b1;
         default: ;
      endcase
   end

   assign pmem_rdata = rbuf;

endmodule

// File: doc/l2_cacheline_adaptor.md
L2_CACHELINE_ADAPTOR -- requirements
Module: l2_cacheline_adaptor

Sits directly downstream of the L2 cache controller. Converts its 256-bit line requests into four 64-bit beats on the physical-memory burst bus.

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (all state updates on rising edge) and rst (asynchronous, active-high).
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 pmem_read  input  1  L2 line-fill request, held until pmem_resp.
REQ-005 pmem_write  input  1  L2 line write-back request, held until pmem_resp.
REQ-006 pmem_address  input  32  L2 line address.
REQ-007 pmem_wdata  input  256  L2 write-back line.
REQ-008 pmem_rdata  output  256  assembled fill line.
REQ-009 pmem_resp  output  1  one-cycle completion pulse to L2.
REQ-010 address_o  output  32  burst-bus address, line aligned.
REQ-011 read_o  output  1  burst read request.
REQ-012 write_o  output  1  burst write request.
REQ-013 burst_o  output  64  outgoing write beat.
REQ-014 burst_i  input  64  incoming read beat.
REQ-015 resp_i  input  1  memory beat acknowledge, one beat per high cycle.

Function
REQ-016 The FSM SHALL have states IDLE, READ, WRITE and DONE.
REQ-017 In IDLE, pmem_write=1 SHALL register address {pmem_address[31:5],5'b0} and pmem_wdata, clear beat counter, and go to WRITE.
REQ-018 In IDLE, pmem_read=1 with pmem_write=0 SHALL register the aligned address, clear the counter, and go to READ.
REQ-019 Simultaneous pmem_read and pmem_write in IDLE SHALL be served as a write; the read is not latched.
REQ-020 READ SHALL drive read_o=1; each cycle with resp_i=1 SHALL store burst_i into rdata bits [64k+63:64k], k = 2-bit counter, then increment k.
REQ-021 WRITE SHALL drive write_o=1 and burst_o = latched wdata bits [64k+63:64k]; each cycle with resp_i=1 SHALL increment k.
REQ-022 Beats need not be consecutive; resp_i=0 cycles SHALL hold k, the buffers and the request line.
REQ-023 resp_i=1 with k=3 SHALL move READ/WRITE to DONE; the counter wraps to 0.
REQ-024 DONE SHALL assert pmem_resp=1 for exactly one cycle with read_o=write_o=0, then go to IDLE.
REQ-025 Latency: with resp_i high every cycle, pmem_resp SHALL rise 5 cycles after the request is accepted in IDLE.
REQ-026 L2 request inputs SHALL be ignored outside IDLE, including the still-asserted request in DONE.
REQ-027 A new request seen in IDLE the cycle after DONE SHALL be accepted with no dead cycle; this covers the write-back then fill sequence.
REQ-028 pmem_rdata SHALL come from the read buffer, be valid in DONE, and hold until the next READ beat.
REQ-029 address_o SHALL be the latched aligned address in READ/WRITE and 0 in IDLE/DONE.
REQ-030 resp_i in IDLE/DONE SHALL be ignored.
REQ-031 burst_o SHALL be 0 outside WRITE.

Reset
REQ-032 rst SHALL immediately force IDLE, counter 0, read buffer 0, write buffer 0 and latched address 0.
REQ-033 During rst, read_o, write_o, pmem_resp, address_o, burst_o and pmem_rdata SHALL all be 0.
REQ-034 rst mid-burst SHALL abandon the transfer with no pmem_resp; the first post-reset request starts at beat 0.

Verification
REQ-035 Read fill: pmem_read, addr 0x0000_1234, resp_i high 4 cycles with beats 0x11..,0x22..,0x33..,0x44.. -> address_o=0x0000_1220, pmem_rdata={44..,33..,22..,11..}, one pmem_resp pulse 5 cycles after accept.
REQ-036 Write-back: pmem_write, wdata=256'hDDDD..CCCC..BBBB..AAAA (4 x 64-bit) -> burst_o AAAA..,BBBB..,CCCC..,DDDD.. on successive resp_i cycles, write_o low in DONE.
REQ-037 Stalled beats: resp_i pattern 1,0,0,1,0,1,1 -> counter holds during gaps, pmem_resp exactly once, rdata correct.
REQ-038 Back-to-back: write completes, L2 switches to pmem_read the cycle after pmem_resp -> read accepted in following IDLE cycle, exactly two pmem_resp pulses total.
REQ-039 Conflict and reset: pmem_read=pmem_write=1 -> write_o only; rst asserted after 2 beats -> all outputs 0 at once, no pmem_resp, next read begins at beat 0.
